decodificador_secded_pipe: RTL and testbench

- Parametrised, pipelined Hamming SECDED decoder. Successor to the combinational 8-bit corrector.
- Computes its own syndrome and overall parity for any data width, then corrects single errors and flags double errors.
- Moves words over a valid/ready stream with backpressure.
- Keeps saturating error-statistics counters and a sticky double-error flag for the board LED; sits between the channel receiver and the data consumer.

---
 rtl/decodificador_secded_pipe.sv | 194 +++++++++++++++++++
 tb/tb_decodificador_secded_pipe.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/decodificador_secded_pipe.sv
// rtl/decodificador_secded_pipe.sv - pipelined Hamming SECDED decoder with valid/ready stream and error statistics
module decodificador_secded_pipe #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8,
    localparam int P = (DATA_W <= 1)   ? 2 :
                       (DATA_W <= 4)   ? 3 :
                       (DATA_W <= 11)  ? 4 :
                       (DATA_W <= 26)  ? 5 :
                       (DATA_W <= 57)  ? 6 :
                       (DATA_W <= 120) ? 7 :
                       (DATA_W <= 247) ? 8 : 9,
    localparam int N = DATA_W + P + 1
) (
    input  logic              reloj,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      recibido,
    input  logic              modo_deteccion,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      palabra_corregida,
    output logic [DATA_W-1:0] corregido,
    output logic [P-1:0]      sindrome,
    output logic              error_simple,
    output logic              error_doble,
    input  logic              clr_contadores,
    output logic [CNT_W-1:0]  cnt_simple,
    output logic [CNT_W-1:0]  cnt_doble,
    output logic              led_doblerror
);

    // Codeword position of data bit j: the j-th non-power-of-two index above 0.
    function automatic int data_pos(input int j);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int i = 1; i < 512; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (cnt == j && pos == 0) begin
                    pos = i;
                end
                cnt++;
            end
        end
        return pos;
    endfunction

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              s1_valid_q, s1_valid_d;
    logic [N-1:0]      s1_word_q, s1_word_d;
    logic              s1_modo_q, s1_modo_d;

    logic              out_valid_q, out_valid_d;
    logic [N-1:0]      pal_q, pal_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [P-1:0]      sind_q, sind_d;
    logic              es_q, es_d;
    logic              ed_q, ed_d;
    logic [CNT_W-1:0]  cnt_s_q, cnt_s_d;
    logic [CNT_W-1:0]  cnt_d_q, cnt_d_d;
    logic              led_q, led_d;

    logic              load2;
    logic              take1;
    logic [P-1:0]      syn;
    logic              par;
    logic              in_range;
    logic              dec_simple;
    logic              dec_doble;
    logic [N-1:0]      fixed;
    logic [DATA_W-1:0] dec_data;

    assign load2    = !out_valid_q || out_ready;
    assign take1    = !s1_valid_q || load2;
    assign in_ready = !reset && take1;

    always_comb begin
        syn = '0;
        for (int i = 1; i < N; i++) begin
            if (s1_word_q[i]) begin
                syn = syn ^ P'(i);
            end
        end
        par        = ^s1_word_q;
        in_range   = ({{(32-P){1'b0}}, syn} < 32'(N));
        dec_simple = par && in_range;
        dec_doble  = (par && !in_range) || (!par && (syn != '0));
        // Detect-only mode and uncorrectable words both pass the codeword through untouched.
        fixed = s1_word_q;
        for (int i = 0; i < N; i++) begin
            if (dec_simple && !s1_modo_q && (syn == P'(i))) begin
                fixed[i] = ~s1_word_q[i];
            end
        end
    end

    for (genvar j = 0; j < DATA_W; j++) begin : g_ext
        localparam int POS = data_pos(j);
        assign dec_data[j] = fixed[POS];
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_word_d   = s1_word_q;
        s1_modo_d   = s1_modo_q;
        out_valid_d = out_valid_q;
        pal_d       = pal_q;
        data_d      = data_q;
        sind_d      = sind_q;
        es_d        = es_q;
        ed_d        = ed_q;
        cnt_s_d     = cnt_s_q;
        cnt_d_d     = cnt_d_q;
        led_d       = led_q;

        if (take1) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_word_d = recibido;
                s1_modo_d = modo_deteccion;
            end
        end

        if (load2) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                pal_d  = fixed;
                data_d = dec_data;
                sind_d = syn;
                es_d   = dec_simple;
                ed_d   = dec_doble;
                if (dec_simple && cnt_s_q != CNT_MAX) begin
                    cnt_s_d = cnt_s_q + 1'b1;
                end
                if (dec_doble) begin
                    led_d = 1'b1;
                    if (cnt_d_q != CNT_MAX) begin
                        cnt_d_d = cnt_d_q + 1'b1;
                    end
                end
            end
        end

        if (clr_contadores) begin
            cnt_s_d = '0;
            cnt_d_d = '0;
            led_d   = 1'b0;
        end
    end

    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_word_q   <= '0;
            s1_modo_q   <= 1'b0;
            out_valid_q <= 1'b0;
            pal_q       <= '0;
            data_q      <= '0;
            sind_q      <= '0;
            es_q        <= 1'b0;
            ed_q        <= 1'b0;
            cnt_s_q     <= '0;
            cnt_d_q     <= '0;
            led_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_word_q   <= s1_word_d;
            s1_modo_q   <= s1_modo_d;
            out_valid_q <= out_valid_d;
            pal_q       <= pal_d;
            data_q      <= data_d;
            sind_q      <= sind_d;
            es_q        <= es_d;
            ed_q        <= ed_d;
            cnt_s_q     <= cnt_s_d;
            cnt_d_q     <= cnt_d_d;
            led_q       <= led_d;
        end
    end

    assign out_valid         = out_valid_q;
    assign palabra_corregida = pal_q;
    assign corregido         = data_q;
    assign sindrome          = sind_q;
    assign error_simple      = es_q;
    assign error_doble       = ed_q;
    assign cnt_simple        = cnt_s_q;
    assign cnt_doble         = cnt_d_q;
    assign led_doblerror     = led_q;

endmodule

// File: tb/tb_decodificador_secded_pipe.sv
// tb/tb_decodificador_secded_pipe.sv - directed self-checking bench for decodificador_secded_pipe
module tb_decodificador_secded_pipe;

    logic       reloj = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] recibido = '0;
    logic       modo = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] pal;
    logic [3:0] corr;
    logic [2:0] sind;
    logic       es, ed;
    logic       clr = 1'b0;
    logic [1:0] cnt_s, cnt_d;
    logic       led;

    logic        in_valid8 = 1'b0;
    logic        in_ready8;
    logic [12:0] rec8 = '0;
    logic        out_valid8;
    logic [12:0] pal8;
    logic [7:0]  corr8;
    logic [3:0]  sind8;
    logic        es8, ed8, led8;
    logic [7:0]  cnt_s8, cnt_d8;

    int total = 0;
    int bad = 0;

    always #5 reloj = ~reloj;

    decodificador_secded_pipe #(.DATA_W(4), .CNT_W(2)) dut (
        .reloj(reloj), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .recibido(recibido), .modo_deteccion(modo), .out_valid(out_valid),
        .out_ready(out_ready), .palabra_corregida(pal), .corregido(corr),
        .sindrome(sind), .error_simple(es), .error_doble(ed),
        .clr_contadores(clr), .cnt_simple(cnt_s), .cnt_doble(cnt_d),
        .led_doblerror(led)
    );

    decodificador_secded_pipe #(.DATA_W(8), .CNT_W(8)) dut8 (
        .reloj(reloj), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .recibido(rec8), .modo_deteccion(1'b0), .out_valid(out_valid8),
        .out_ready(1'b1), .palabra_corregida(pal8), .corregido(corr8),
        .sindrome(sind8), .error_simple(es8), .error_doble(ed8),
        .clr_contadores(1'b0), .cnt_simple(cnt_s8), .cnt_doble(cnt_d8),
        .led_doblerror(led8)
    );

    task automatic comprobar(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] w, input logic m);
        @(negedge reloj);
        in_valid = 1'b1;
        recibido = w;
        modo     = m;
        @(negedge reloj);
        in_valid = 1'b0;
        modo     = 1'b0;
        @(negedge reloj);
    endtask

    task automatic pulse_clr();
        @(negedge reloj);
        clr = 1'b1;
        @(negedge reloj);
        clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge reloj);
        #1;
        comprobar("rst_in_ready", in_ready, 0);
        comprobar("rst_out_valid", out_valid, 0);
        comprobar("rst_pal", pal, 0);
        comprobar("rst_cnt_s", cnt_s, 0);
        comprobar("rst_led", led, 0);
        @(negedge reloj);
        reset = 1'b0;
        #1;
        comprobar("rel_in_ready", in_ready, 1);

        send(8'hAA, 1'b0);
        comprobar("clean_valid", out_valid, 1);
        comprobar("clean_corr", corr, 4'b1011);
        comprobar("clean_pal", pal, 8'hAA);
        comprobar("clean_sind", sind, 0);
        comprobar("clean_flags", {es, ed}, 2'b00);
        comprobar("clean_cnt_s", cnt_s, 0);

        send(8'h8A, 1'b0);
        comprobar("se_sind", sind, 5);
        comprobar("se_flags", {es, ed}, 2'b10);
        comprobar("se_pal", pal, 8'hAA);
        comprobar("se_corr", corr, 4'b1011);
        comprobar("se_cnt_s", cnt_s, 1);

        send(8'hAB, 1'b0);
        comprobar("p0_sind", sind, 0);
        comprobar("p0_flags", {es, ed}, 2'b10);
        comprobar("p0_pal", pal, 8'hAA);
        comprobar("p0_cnt_s", cnt_s, 2);

        send(8'h88, 1'b0);
        comprobar("de_sind", sind, 4);
        comprobar("de_flags", {es, ed}, 2'b01);
        comprobar("de_pal", pal, 8'h88);
        comprobar("de_cnt_d", cnt_d, 1);
        comprobar("de_led", led, 1);
        send(8'hAA, 1'b0);
        comprobar("led_sticky", led, 1);
        pulse_clr();
        #1;
        comprobar("clr_led", led, 0);
        comprobar("clr_cnt_s", cnt_s, 0);
        comprobar("clr_cnt_d", cnt_d, 0);

        send(8'h8A, 1'b1);
        comprobar("dt_flags", {es, ed}, 2'b10);
        comprobar("dt_sind", sind, 5);
        comprobar("dt_pal", pal, 8'h8A);
        comprobar("dt_corr", corr, 4'b1001);

        @(negedge reloj);
        in_valid8 = 1'b1;
        rec8      = 13'h1005;
        @(negedge reloj);
        in_valid8 = 1'b0;
        @(negedge reloj);
        comprobar("w8_valid", out_valid8, 1);
        comprobar("w8_flags", {es8, ed8}, 2'b01);
        comprobar("w8_sind", sind8, 14);
        comprobar("w8_pal", pal8, 13'h1005);

        pulse_clr();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        recibido  = 8'h00;
        #1;
        comprobar("bp_rdy0", in_ready, 1);
        @(negedge reloj);
        recibido = 8'hAA;
        #1;
        comprobar("bp_rdy1", in_ready, 1);
        @(negedge reloj);
        recibido = 8'h88;
        #1;
        comprobar("bp_rdy2", in_ready, 0);
        comprobar("bp_v0", out_valid, 1);
        comprobar("bp_w0", pal, 8'h00);
        @(negedge reloj);
        @(negedge reloj);
        #1;
        comprobar("bp_hold_rdy", in_ready, 0);
        comprobar("bp_hold_w0", pal, 8'h00);
        comprobar("bp_hold_v", out_valid, 1);
        out_ready = 1'b1;
        @(negedge reloj);
        in_valid = 1'b0;
        comprobar("bp_w1", pal, 8'hAA);
        comprobar("bp_v1", out_valid, 1);
        @(negedge reloj);
        comprobar("bp_w2", pal, 8'h88);
        comprobar("bp_w2_ed", ed, 1);
        @(negedge reloj);
        comprobar("bp_empty", out_valid, 0);

        pulse_clr();
        for (int i = 0; i < 5; i++) begin
            send(8'h8A, 1'b0);
        end
        comprobar("sat_cnt_s", cnt_s, 3);

        @(negedge reloj);
        in_valid = 1'b1;
        recibido = 8'h8A;
        @(negedge reloj);
        in_valid = 1'b0;
        clr      = 1'b1;
        @(negedge reloj);
        clr = 1'b0;
        comprobar("clrinc_es", es, 1);
        comprobar("clrinc_cnt_s", cnt_s, 0);

        @(negedge reloj);
        in_valid = 1'b1;
        recibido = 8'h88;
        @(negedge reloj);
        recibido = 8'hAA;
        @(negedge reloj);
        in_valid = 1'b0;
        comprobar("mid_led", led, 1);
        comprobar("mid_cnt_d", cnt_d, 1);
        #1;
        reset = 1'b1;
        #1;
        comprobar("mid_rst_ov", out_valid, 0);
        comprobar("mid_rst_rdy", in_ready, 0);
        comprobar("mid_rst_cnt_d", cnt_d, 0);
        comprobar("mid_rst_led", led, 0);
        @(negedge reloj);
        reset = 1'b0;
        #1;
        comprobar("mid_rel_rdy", in_ready, 1);
        comprobar("mid_rel_ov", out_valid, 0);
        @(negedge reloj);
        comprobar("mid_drop_ov", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
